bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD encoder for the Snake game score path, using shift-and-add-3 (double dabble), one bit per clock.
- Takes an unsigned binary score on a start strobe and returns DIGITS packed BCD digits with a one-cycle done pulse.
- Each 4-bit output digit drives one seven-segment digit decoder on the board display.
- Built to avoid a wide combinational divider chain in the game clock domain.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 20 ++
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the Snake score path: converter FSM states,
// BCD digit constants and the default score width / digit count.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int          BCD_W        = 4;
  localparam logic [3:0]  BCD_NINE     = 4'h9;
  localparam int          SCORE_W      = 14;
  localparam int          SCORE_DIGITS = 4;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned dec_max(input int digits);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries into the next decade.
module bcd_add3
  import snake_pkg::*;
(
  input  logic [BCD_W-1:0] i_dig,
  output logic [BCD_W-1:0] o_dig
);

  // Correct one digit ahead of the shift.
  always_comb begin
    o_dig = i_dig;
    if (i_dig >= 4'd5) begin
      o_dig = i_dig + 4'd3;
    end else begin
      o_dig = i_dig;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// for the score display. Values above 10^DIGITS-1 saturate to all nines.
module bin2bcd_seq
  import snake_pkg::*;
#(
  parameter int W      = SCORE_W,
  parameter int DIGITS = SCORE_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [W-1:0]          i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic                  o_ovf
);

  localparam int              ACC_W = BCD_W * DIGITS;
  localparam int              CNT_W = $clog2(W + 1);
  localparam longint unsigned MAX   = dec_max(DIGITS);

  state_e             state_q, state_d;
  logic [W-1:0]       sreg_q, sreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic [W-1:0]       sreg_shift_s;
  logic [63:0]        bin_ext_s;
  logic               bin_ovf_s;
  logic               load_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_dig (acc_q[g*BCD_W +: BCD_W]),
        .o_dig (acc_adj_s[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  assign acc_shift_s  = {acc_adj_s[ACC_W-2:0], sreg_q[W-1]};
  assign sreg_shift_s = {sreg_q[W-2:0], 1'b0};
  assign bin_ext_s    = 64'(i_bin);
  assign bin_ovf_s    = (bin_ext_s > MAX);

  // A start is also taken in DONE so back-to-back requests keep the
  // W+1 cycle cadence; o_busy still reads high for that one cycle.
  assign load_s = i_start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (load_s) begin
          sreg_d     = i_bin;
          acc_d      = '0;
          cnt_d      = CNT_W'(W);
          ovf_pend_d = bin_ovf_s;
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        acc_d  = acc_shift_s;
        sreg_d = sreg_shift_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovf_pend_q ? {DIGITS{BCD_NINE}} : acc_shift_s;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_bcd  = bcd_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed scenarios plus random traffic,
// expected digits computed with decimal arithmetic.
module tb_bin2bcd_seq;

  localparam int W      = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = W + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  int          busy_left = 0;
  logic [16:0] exp_hold  = '0;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_bcd   (bcd),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_conv(input int unsigned v);
    logic [16:0] r;
    int unsigned x;
    r = '0;
    if (v > 9999) begin
      r = {1'b1, 16'h9999};
    end else begin
      x = v;
      for (int i = 0; i < 4; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: acceptance and busy/done timing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = 0;
      exp_q.delete();
    end else if (start && busy_left <= 1) begin
      exp_q.push_back(ref_conv(32'(bin)));
      busy_left = LAT;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
    end
  end

  // Monitor: compare outputs every cycle, pop on done.
  always @(negedge clk) begin
    if (!rst_n) exp_hold = '0;
    chk("busy", 32'(busy), 32'(busy_left > 0));
    chk("done", 32'(done), 32'(busy_left == 1));
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_hold = exp_q.pop_front();
      end
    end
    chk("bcd", 32'(bcd), 32'(exp_hold[15:0]));
    chk("ovf", 32'(ovf), 32'(exp_hold[16]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic convert(input logic [13:0] v);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 14'($urandom);
    repeat (LAT + 1) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    convert(14'd0);
    convert(14'd1234);
    convert(14'd9999);
    convert(14'd10);
    convert(14'd12000);
    convert(14'd7);
    convert(14'd10000);

    // Starts during a conversion are ignored.
    start = 1'b1;
    bin   = 14'd42;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      start = (c == 3 || c == 14);
      bin   = 14'd99;
      tick();
    end
    start = 1'b0;
    repeat (3) tick();

    // Reset mid-conversion discards it.
    start = 1'b1;
    bin   = 14'd5678;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    convert(14'd321);

    // Start held high: back-to-back conversions.
    start = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      bin = 14'(v);
      repeat (LAT) tick();
    end
    start = 1'b0;
    repeat (LAT + 2) tick();

    // Random traffic with start noise while busy.
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       bin = 14'd9999;
        1:       bin = 14'd10000;
        2:       bin = 14'($urandom_range(0, 99));
        default: bin = 14'($urandom);
      endcase
      tick();
    end
    start = 1'b0;
    repeat (LAT + 2) tick();

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
